// File: rtl/mem_bist.sv
// ---------------------------------------------------------------------------
// mem_bist -- built-in self-test engine for one dual-port block RAM.
//
// A start pulse in IDLE latches the selected algorithm and runs it to the end.
// The engine writes through port A, reads back through port B, compares the
// data on the fly, and reports pass/fail, a saturating error count and the
// first failing location.
//
// Algorithms (one full address sweep per element, one DRAIN cycle after each):
//   mode 0 ADDR    : W(ADDR)up, R(ADDR)up
//   mode 1 CHECKER : W(CHK)up, R(CHK)up, W(~CHK)up, R(~CHK)up
//   mode 2 MARCH   : W(0)up, RW(0,1s)up, RW(1s,0)down, R(0)up
//   mode 3         : reserved; goes straight to FIN with pass=0
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-low reset
//   start, mode        start pulse and algorithm select (both sampled in IDLE)
//   busy, done, pass   test running / one-cycle end pulse / result
//   err_count          mismatches in the current/last test, saturating
//   fail_addr/_data    address and observed data of the first mismatch
//   addr_a/data_a/we_a write port A
//   addr_b/data_b/we_b read port B (data_b and we_b tied to 0)
//   q_b                port B read data, valid one cycle after addr_b
// ---------------------------------------------------------------------------
module mem_bist #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  we_b,
  input  logic [DATA_WIDTH-1:0] q_b
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_e;
  typedef enum logic [1:0] {K_W, K_R, K_RW} kind_e;
  typedef enum logic [2:0] {P_ZERO, P_ONES, P_ADDR, P_CHK, P_NCHK} pat_e;

  typedef struct packed {
    kind_e kind;
    logic  down;    // sweep N-1..0 instead of 0..N-1
    pat_e  rd_pat;  // expected read value
    pat_e  wr_pat;  // value written (W, or trailing write of RW)
  } elem_t;

  // Element table: algorithm + element index -> operation.
  function automatic elem_t elem_of(input logic [1:0] m, input logic [1:0] e);
    elem_t el;
    el.kind   = K_W;
    el.down   = 1'b0;
    el.rd_pat = P_ZERO;
    el.wr_pat = P_ZERO;
    case (m)
      2'd0: begin
        el.kind   = e[0] ? K_R : K_W;
        el.rd_pat = P_ADDR;
        el.wr_pat = P_ADDR;
      end
      2'd1: begin
        el.kind   = e[0] ? K_R : K_W;
        el.rd_pat = e[1] ? P_NCHK : P_CHK;
        el.wr_pat = e[1] ? P_NCHK : P_CHK;
      end
      2'd2: begin
        case (e)
          2'd1: begin
            el.kind   = K_RW;
            el.wr_pat = P_ONES;
          end
          2'd2: begin
            el.kind   = K_RW;
            el.down   = 1'b1;
            el.rd_pat = P_ONES;
          end
          2'd3:    el.kind = K_R;
          default: el.kind = K_W;
        endcase
      end
      default: ;
    endcase
    return el;
  endfunction

  // Data pattern for a given address.
  function automatic logic [DATA_WIDTH-1:0] pat_val(input pat_e p,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    case (p)
      P_ONES: v = '1;
      P_ADDR: begin
        // Address replicated across the word, truncated to DATA_WIDTH bits.
        for (int b = 0; b < DATA_WIDTH; b++) v[b] = a[b % ADDR_WIDTH];
      end
      P_CHK, P_NCHK: begin
        // 0x..5555 on even addresses, 0x..AAAA on odd ones.
        for (int b = 0; b < DATA_WIDTH; b++) v[b] = ((b % 2) == 0) ^ a[0];
        if (p == P_NCHK) v = ~v;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [1:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_valid_q, rd_valid_d;   // a read was issued last cycle
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;     // its address
  logic [DATA_WIDTH-1:0] exp_q, exp_d;             // its expected data
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic                  pass_q, pass_d;

  elem_t                 cur, nxt;
  logic [1:0]            last_elem;
  logic [ADDR_WIDTH-1:0] end_addr;
  logic                  mismatch;

  assign cur       = elem_of(mode_q, elem_q);
  assign nxt       = elem_of(mode_q, elem_q + 2'd1);
  assign last_elem = (mode_q == 2'd0) ? 2'd1 : 2'd3;
  assign end_addr  = cur.down ? {ADDR_WIDTH{1'b0}} : {ADDR_WIDTH{1'b1}};
  // q_b is the answer to the read issued one cycle earlier.
  assign mismatch  = rd_valid_q && (q_b != exp_q);

  // NOTE: every output and next-state value gets a default at the top of the
  // block, so no path through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    rd_valid_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    exp_d       = exp_q;
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    pass_d      = pass_q;
    we_a        = 1'b0;
    addr_a      = '0;
    data_a      = '0;
    addr_b      = '0;

    // Registered compare; the first mismatch of a test is the one with the
    // error count still at zero.
    if (mismatch) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      if (err_count_q == 16'd0) begin
        fail_addr_d = rd_addr_q;
        fail_data_d = q_b;
      end
    end

    // Trailing write of an RW element: the address read last cycle. The read
    // counter has already moved on, so the two ports never collide. The last
    // one of the sweep lands in the DRAIN cycle.
    if ((state_q == S_RUN || state_q == S_DRAIN) && rd_valid_q && cur.kind == K_RW) begin
      we_a   = 1'b1;
      addr_a = rd_addr_q;
      data_a = pat_val(cur.wr_pat, rd_addr_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          elem_d      = 2'd0;
          addr_d      = '0;
          err_count_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pass_d      = 1'b0;
          state_d     = (mode == 2'd3) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (cur.kind == K_W) begin
          we_a   = 1'b1;
          addr_a = addr_q;
          data_a = pat_val(cur.wr_pat, addr_q);
        end else begin
          addr_b     = addr_q;
          rd_valid_d = 1'b1;
          rd_addr_d  = addr_q;
          exp_d      = pat_val(cur.rd_pat, addr_q);
        end
        if (addr_q == end_addr) state_d = S_DRAIN;
        else if (cur.down)      addr_d  = addr_q - ADDR_WIDTH'(1);
        else                    addr_d  = addr_q + ADDR_WIDTH'(1);
      end
      S_DRAIN: begin
        if (elem_q == last_elem) begin
          state_d = S_FIN;
          // Includes the compare of the final read, resolved this cycle.
          pass_d  = (err_count_d == 16'd0);
        end else begin
          elem_d  = elem_q + 2'd1;
          addr_d  = nxt.down ? {ADDR_WIDTH{1'b1}} : {ADDR_WIDTH{1'b0}};
          state_d = S_RUN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      elem_q      <= 2'd0;
      addr_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      exp_q       <= '0;
      err_count_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      exp_q       <= exp_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      pass_q      <= pass_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_FIN);
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign data_b    = '0;
  assign we_b      = 1'b0;

endmodule

// File: tb/tb_mem_bist.sv
// ---------------------------------------------------------------------------
// tb_mem_bist -- directed self-checking bench for mem_bist with a 16x16
// dual-port RAM model that can inject a stuck-at fault on its read path.
// ---------------------------------------------------------------------------
module tb_mem_bist;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          busy, done, pass, we_a, we_b;
  logic [15:0]   err_count;
  logic [AW-1:0] fail_addr, addr_a, addr_b;
  logic [DW-1:0] fail_data, data_a, data_b, q_b;

  int checks = 0;
  int errors = 0;

  // RAM model; fault_sel 1 = addr 5 bit 0 stuck-at-1, 2 = addr 3 stuck at 0xFFFF.
  logic [DW-1:0] mem [N];
  int            fault_sel = 0;
  logic [AW-1:0] ab_log [128];

  mem_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data),
    .addr_a(addr_a), .data_a(data_a), .we_a(we_a),
    .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    logic [DW-1:0] rd;
    if (we_a) mem[addr_a] <= data_a;
    rd = mem[addr_b];
    if (fault_sel == 1 && addr_b == AW'(5)) rd[0] = 1'b1;
    if (fault_sel == 2 && addr_b == AW'(3)) rd = 16'hFFFF;
    q_b <= rd;
  end

  // Pulses start, then follows the run cycle by cycle (sampled on negedges)
  // until done; optionally re-pulses start or asserts reset at a busy cycle.
  task automatic do_run(input logic [1:0] m, input int pulse_at, input int rst_at,
                        output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'd1;   // changes after acceptance must be ignored
    for (int c = 0; c < 300; c++) begin
      if (busy) begin
        ab_log[busy_cnt] = addr_b;
        busy_cnt++;
      end
      if (done) begin
        done_cnt++;
        return;
      end
      if (busy_cnt == rst_at) begin
        rst = 1'b0;
        return;
      end
      start = (busy_cnt == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %0b want 0", pass); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err got %0h want 0", err_count); end
    checks++; if ({fail_addr, fail_data} !== '0) begin errors++; $display("FAIL reset_fail got %0h/%0h want 0/0", fail_addr, fail_data); end
    checks++; if ({we_a, addr_a, data_a, addr_b, data_b, we_b} !== '0) begin
      errors++; $display("FAIL reset_ports we_a=%0b addr_a=%0h data_a=%0h addr_b=%0h want all 0", we_a, addr_a, data_a, addr_b);
    end
    rst = 1'b1;
  endtask

  task automatic test_addr_mode;
    int bc, dc;
    fault_sel = 0;
    do_run(2'd0, -1, -1, bc, dc);
    checks++; if (bc != 34) begin errors++; $display("FAIL addr_busy_len got %0d want 34", bc); end
    checks++; if (dc != 1) begin errors++; $display("FAIL addr_done got %0d want 1", dc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL addr_busy_at_done got %0b want 0", busy); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL addr_pass got %0b want 1", pass); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL addr_err got %0h want 0", err_count); end
    checks++; if (mem[5] !== 16'h5555) begin errors++; $display("FAIL addr_word5 got %0h want 5555", mem[5]); end
    checks++; if (mem[10] !== 16'hAAAA) begin errors++; $display("FAIL addr_word10 got %0h want aaaa", mem[10]); end
    checks++; if (mem[12] !== 16'hCCCC) begin errors++; $display("FAIL addr_word12 got %0h want cccc", mem[12]); end
  endtask

  task automatic test_march;
    int bc, dc, bad;
    fault_sel = 0;
    do_run(2'd2, -1, -1, bc, dc);
    checks++; if (bc != 68) begin errors++; $display("FAIL march_busy_len got %0d want 68", bc); end
    checks++; if (dc != 1) begin errors++; $display("FAIL march_done got %0d want 1", dc); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL march_pass got %0b want 1", pass); end
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== 16'h0000) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL march_mem_zero got %0d nonzero words want 0", bad); end
    // Third element (descending) occupies busy cycles 34..49.
    for (int j = 0; j < N; j++) begin
      checks++;
      if (ab_log[34 + j] !== AW'(15 - j)) begin
        errors++; $display("FAIL march_desc_addr_b[%0d] got %0d want %0d", j, ab_log[34 + j], 15 - j);
      end
    end
  endtask

  task automatic test_march_fault;
    int bc, dc;
    fault_sel = 1;
    do_run(2'd2, -1, -1, bc, dc);
    fault_sel = 0;
    checks++; if (dc != 1) begin errors++; $display("FAIL mfault_done got %0d want 1", dc); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL mfault_err got %0d want 2", err_count); end
    checks++; if (fail_addr !== AW'(5)) begin errors++; $display("FAIL mfault_addr got %0d want 5", fail_addr); end
    checks++; if (fail_data !== 16'h0001) begin errors++; $display("FAIL mfault_data got %0h want 0001", fail_data); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mfault_pass got %0b want 0", pass); end
  endtask

  task automatic test_checker_fault;
    int bc, dc, seen;
    fault_sel = 2;
    do_run(2'd1, -1, -1, bc, dc);
    fault_sel = 0;
    checks++; if (bc != 68) begin errors++; $display("FAIL cfault_busy_len got %0d want 68", bc); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL cfault_err got %0d want 2", err_count); end
    checks++; if (fail_addr !== AW'(3)) begin errors++; $display("FAIL cfault_addr got %0d want 3", fail_addr); end
    checks++; if (fail_data !== 16'hFFFF) begin errors++; $display("FAIL cfault_data got %0h want ffff", fail_data); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL cfault_pass got %0b want 0", pass); end
    // A new start clears the previous result within one cycle.
    @(negedge clk);
    mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL restart_err got %0d want 0", err_count); end
    checks++; if ({fail_addr, fail_data} !== '0) begin errors++; $display("FAIL restart_fail got %0h/%0h want 0/0", fail_addr, fail_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %0b want 1", busy); end
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL restart_done_timeout got %0d want 1", seen); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL restart_pass got %0b want 1", pass); end
  endtask

  task automatic test_back_to_back;
    int bc, dc, extra;
    do_run(2'd0, 10, -1, bc, dc);
    checks++; if (bc != 34) begin errors++; $display("FAIL b2b_busy_len got %0d want 34", bc); end
    checks++; if (dc != 1) begin errors++; $display("FAIL b2b_done got %0d want 1", dc); end
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_extra_activity got %0d want 0", extra); end
  endtask

  task automatic test_reset_abort;
    int bc, dc, seen;
    fault_sel = 1;
    do_run(2'd2, -1, 20, bc, dc);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
    checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL abort_we_a got %0b want 0", we_a); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL abort_err got %0d want 0", err_count); end
    rst = 1'b1;
    fault_sel = 0;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", seen); end
    do_run(2'd3, -1, -1, bc, dc);
    checks++; if (dc != 1) begin errors++; $display("FAIL mode3_done got %0d want 1", dc); end
    checks++; if (bc != 0) begin errors++; $display("FAIL mode3_busy got %0d want 0", bc); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL mode3_pass got %0b want 0", pass); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL mode3_err got %0d want 0", err_count); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    test_reset;
    test_addr_mode;
    test_march;
    test_march_fault;
    test_checker_fault;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bist.md
# mem_bist

Parametrised built-in self-test engine for one dual-port block RAM (`bram`) of arbitrary data width and depth. On a `start` pulse it runs one of three selectable test algorithms: address pattern, checkerboard, or reduced March C-. It writes through port A, reads back through port B, compares on the fly, and reports pass/fail, an error count and the first failing location. It replaces single-pattern test FSMs in memory test tops and connects straight to the `bram` ports.

## Interface
- `DATA_WIDTH`, 16, memory word width (≥2)
- `ADDR_WIDTH`, 10, address width; depth N = 2**ADDR_WIDTH
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-low
- `start`  in  1  begin test; sampled only in IDLE
- `mode`  in  2  0 = ADDR, 1 = CHECKER, 2 = MARCH, 3 = reserved; latched with `start`
- `busy`  out  1  test in progress
- `done`  out  1  one-cycle pulse at end of test
- `pass`  out  1  valid after `done`; held until next accepted `start`
- `err_count`  out  16  mismatches in the current/last test, saturating at 0xFFFF
- `fail_addr`  out  ADDR_WIDTH  address of first mismatch
- `fail_data`  out  DATA_WIDTH  data observed at first mismatch
- `addr_a`, `data_a`, `we_a`  out  ADDR_WIDTH/DATA_WIDTH/1  write port
- `addr_b`  out  ADDR_WIDTH  read address
- `data_b`, `we_b`  out  DATA_WIDTH/1  tied to 0
- `q_b`  in  DATA_WIDTH  read data; valid exactly one cycle after `addr_b`

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- Each test is a list of elements. An element sweeps all N addresses, one per cycle, ascending (0..N-1) or descending (N-1..0). It is followed by one DRAIN cycle, then the next element.
- Element kinds:
  - W(v): write v to port A.
  - R(v): read on port B and compare with v one cycle later.
  - RW(v, w): read port B at addr i in cycle t, compare with v at t+1, and write w to addr i on port A at t+1. Writes never hit the address being read in the same cycle.
- Pattern values:
  - ADDR(i): addr i replicated, truncated to the low DATA_WIDTH bits.
  - CHK(i): 0x…5555 if i[0]=0, else 0x…AAAA.
  - ~CHK(i): bitwise inverse of CHK(i).
- Mode 0 (ADDR): W(ADDR)↑, R(ADDR)↑.
- Mode 1 (CHECKER): W(CHK)↑, R(CHK)↑, W(~CHK)↑, R(~CHK)↑.
- Mode 2 (MARCH): W(0)↑, RW(0, all-ones)↑, RW(all-ones, 0)↓, R(0)↑.
- Mode 3: no memory access; FIN the cycle after start; `pass`=0, `err_count`=0.
- On mismatch:
  - `err_count` increments, saturating.
  - On the first mismatch of the test only, capture `fail_addr` and `fail_data` (observed `q_b`).
- At FIN: `pass` = (`err_count`==0 && mode≠3).
- Accepted `start` clears `err_count`, `fail_addr`, `fail_data` and `pass`.
- `start` while busy is ignored; `mode` changes during a test are ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_addr`=0, `fail_data`=0, all address/data outputs 0, `we_a`=0. `we_b` and `data_b` are always 0.
- Reset mid-test aborts at the next edge. `we_a` is low from that edge on; no partial result is reported.
- Start handshake:
  - Start sampled at edge k.
  - `busy`=1 and the first access are presented from cycle k+1.
  - Busy length = E·(N+1) cycles, where E = element count (2, 4, 4).
- End of test: `done`=1 and `busy`=0 in the cycle after the final DRAIN. FIN returns to IDLE after one cycle.
- Compare is registered. `err_count` reflects a mismatch two cycles after the corresponding `addr_b`; the final DRAIN cycle covers the last compare.
- Address counter wraps N-1→0 (↑) or 0→N-1 (↓) only at element boundaries; no access is issued in DRAIN.
- `we_a` is high only in W cycles and in the trailing-write cycles of RW elements.

## Test plan
- ADDR_WIDTH=4, DATA_WIDTH=16, mode 0, ideal bram:
  - busy for exactly 34 cycles, `done` pulse.
  - `pass`=1, `err_count`=0.
  - Memory word 5 = 0x5555 afterwards.
- Mode 2, ideal bram:
  - busy 68 cycles, `pass`=1.
  - All 16 words read 0x0000 afterwards.
  - Descending element issues `addr_b` 15,14,…,0.
- Mode 2, bench model with addr 5 bit 0 stuck-at-1:
  - `err_count`=2, `fail_addr`=5, `fail_data`=0x0001, `pass`=0.
- Mode 1, model with addr 3 stuck at 0xFFFF:
  - `err_count`=2, `fail_addr`=3, `fail_data`=0xFFFF.
- `start` pulsed again at cycle 10 of a mode-0 run:
  - Ignored; single `done` at cycle 34.
  - Then a new start clears `err_count` to 0 within one cycle.
- Reset driven low at cycle 20 of mode 2:
  - Next edge: `busy`=0, `we_a`=0, `err_count`=0.
  - No `done`.
  - Mode 3 start afterwards gives `done` on the next cycle, `pass`=0.
